// File: rtl/udp_dff_pkg.sv
// udp_dff_pkg -- shared constants and types for the udp_dff register.
//   RESET_VAL / PRESET_VAL : per-bit forced values for rst and preset.
//   dff_pri_e              : per-bit action priority (RST > PRESET > CAPTURE).
//   dff_pri()              : maps the async controls onto dff_pri_e; an X on a
//                            control that is not overridden yields an X code.
package udp_dff_pkg;
    timeunit 1ns;
    timeprecision 100ps;

    localparam logic RESET_VAL  = 1'b0;
    localparam logic PRESET_VAL = 1'b1;

    typedef enum logic [1:0] {
        PRI_RST     = 2'd0,
        PRI_PRESET  = 2'd1,
        PRI_CAPTURE = 2'd2
    } dff_pri_e;

    // Ternaries rather than if/else so an unknown control merges the
    // candidate codes into X instead of silently picking a branch.
    function automatic dff_pri_e dff_pri(input logic rst, input logic preset);
        return (!rst) ? PRI_RST : ((!preset) ? PRI_PRESET : PRI_CAPTURE);
    endfunction
endpackage

// File: rtl/udp_dff_bit.sv
// udp_dff_bit -- one bit of the udp_dff register.
// Ports:
//   clk    in  rising-edge capture clock
//   rst    in  async active-low clear (highest priority)
//   preset in  async active-low set
//   cap_en in  capture qualifier for rising clk edges
//   d      in  next-state data
//   q      out registered state
module udp_dff_bit
    import udp_dff_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic preset,
    input  logic cap_en,
    input  logic d,
    output logic q
);
    timeunit 1ns;
    timeprecision 100ps;

    logic q_q;
    logic set_n;

    // The preset is qualified by rst so that releasing rst while preset is
    // still low produces a falling edge here and the bit jumps to 1
    // immediately, matching a level-sensitive reset-dominant set/clear flop.
    assign set_n = ~rst | preset;

    always_ff @(posedge clk or negedge rst or negedge set_n) begin
        case (dff_pri(rst, preset))
            PRI_RST:     q_q <= RESET_VAL;
            PRI_PRESET:  q_q <= PRESET_VAL;
            PRI_CAPTURE: if (cap_en) q_q <= d;
            default:     q_q <= 1'bx;
        endcase
    end

    assign q = q_q;
endmodule

// File: rtl/udp_dff.sv
// udp_dff -- WIDTH-bit D register with async active-low clear and preset.
// Ports (positional order is fixed: nstate, clk, preset, rst, d[, clk_en]):
//   nstate out [WIDTH] registered state
//   clk    in          rising-edge capture clock
//   preset in          async active-low set to all-ones
//   rst    in          async active-low clear to all-zeros (wins over preset)
//   d      in  [WIDTH] next-state data
//   clk_en in          capture enable, present only with UDP_DFF_CLK_EN_EN
// Optional feature macro: UDP_DFF_CLK_EN_EN.
module udp_dff
    import udp_dff_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] nstate,
    input  logic             clk,
    input  logic             preset,
    input  logic             rst,
    input  logic [WIDTH-1:0] d
`ifdef UDP_DFF_CLK_EN_EN
    ,
    input  logic             clk_en
`endif
);
    timeunit 1ns;
    timeprecision 100ps;

    logic cap_en;

`ifdef UDP_DFF_CLK_EN_EN
    assign cap_en = clk_en;
`else
    assign cap_en = 1'b1;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        udp_dff_bit u_bit (
            .clk    (clk),
            .rst    (rst),
            .preset (preset),
            .cap_en (cap_en),
            .d      (d[i]),
            .q      (nstate[i])
        );
    end
endmodule

// File: tb/tb_udp_dff.sv
module tb_udp_dff;
    timeunit 1ns;
    timeprecision 100ps;

    typedef struct {
        realtime    t;
        logic [7:0] v;
        string      name;
    } chk_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       preset = 1'b1;
    logic [7:0] d      = 8'h00;
    logic       clk_en = 1'b1;
    logic [7:0] nstate;
    logic [7:0] xval;

    chk_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    bit   stim_done = 1'b0;

    udp_dff #(.WIDTH(8)) dut (
        .nstate (nstate),
        .clk    (clk),
        .preset (preset),
        .rst    (rst),
        .d      (d)
`ifdef UDP_DFF_CLK_EN_EN
        ,
        .clk_en (clk_en)
`endif
    );

    initial forever #1 clk = ~clk;

    task automatic at_time(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic expect_at(input realtime t, input logic [7:0] v, input string name);
        chk_t e;
        e.t = t;
        e.v = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        at_time(0.0);  rst = 1'b0; preset = 1'b0; d = 8'h00; clk_en = 1'b1;
        expect_at(0.2, 8'h00, "s1_rst_prio");
        at_time(0.2);
        checks++;
        if (nstate !== 8'h00) begin
            failures++;
            $display("FAIL direct_s1: nstate=%h expected=00 at t=%0t", nstate, $realtime);
        end
        at_time(3.0);  preset = 1'b1;
        expect_at(3.5, 8'h00, "s2_rst_hold_e3");
        expect_at(5.5, 8'h00, "s2_rst_hold_e5");
        at_time(6.0);  rst = 1'b1; d = 8'h00;
        expect_at(6.5, 8'h00, "s3_after_rel");
        expect_at(7.5, 8'h00, "s3_cap_zero");
        at_time(8.0);  d = 8'h3C;
        expect_at(8.5, 8'h00, "s3_before_edge");
        expect_at(9.5, 8'h3C, "s3_cap_3c");
        at_time(10.0); d = 8'hC3;
        expect_at(10.5, 8'h3C, "s3_d_between_edges");
        expect_at(11.5, 8'hC3, "s3_cap_c3");
        at_time(12.0); preset = 1'b0; d = 8'h00;
        expect_at(12.2, 8'hFF, "s4_preset_imm");
        at_time(12.2);
        checks++;
        if (nstate !== 8'hFF) begin
            failures++;
            $display("FAIL direct_s4_preset: nstate=%h expected=ff at t=%0t", nstate, $realtime);
        end
        expect_at(13.5, 8'hFF, "s4_preset_e13");
        expect_at(15.5, 8'hFF, "s4_preset_e15");
        at_time(17.0); rst = 1'b0;
        expect_at(17.2, 8'h00, "s4_rst_over_preset");
        at_time(17.2);
        checks++;
        if (nstate !== 8'h00) begin
            failures++;
            $display("FAIL direct_s4_rst: nstate=%h expected=00 at t=%0t", nstate, $realtime);
        end
        at_time(18.0); rst = 1'b1;
        expect_at(18.2, 8'hFF, "rst_rel_preset_low");
        at_time(18.2);
        checks++;
        if (nstate !== 8'hFF) begin
            failures++;
            $display("FAIL direct_rst_rel: nstate=%h expected=ff at t=%0t", nstate, $realtime);
        end
        at_time(18.6); preset = 1'b1; d = 8'h5A;
        expect_at(18.8, 8'hFF, "preset_rel_hold");
        expect_at(19.5, 8'h5A, "preset_rel_cap");
        at_time(20.0); rst = 1'b0;
        expect_at(20.2, 8'h00, "rst_pulse_imm");
        at_time(20.6); rst = 1'b1; d = 8'h77;
        expect_at(20.8, 8'h00, "rst_rel_hold");
        expect_at(21.5, 8'h77, "rst_rel_cap");
`ifdef UDP_DFF_CLK_EN_EN
        at_time(22.0); clk_en = 1'b0; d = 8'hA5;
        expect_at(23.5, 8'h77, "s5_en_low_e23");
        expect_at(25.5, 8'h77, "s5_en_low_e25");
        at_time(26.0); clk_en = 1'b1;
        expect_at(27.5, 8'hA5, "s5_en_high_cap");
`else
        at_time(22.0); d = 8'hA5;
        expect_at(23.5, 8'hA5, "s5_cap_a5");
        at_time(24.0); d = 8'h96;
        expect_at(25.5, 8'h96, "s5_cap_96");
`endif
        at_time(28.0); xval = 'x; d = xval;
        expect_at(29.5, xval, "s6_cap_x");
        at_time(30.0); d = 8'h00;
        expect_at(31.5, 8'h00, "s6_cap_zero");
        at_time(32.0); d = 8'h81;
        expect_at(32.5, 8'h00, "s6_hold_falling");
        expect_at(33.5, 8'h81, "s6_cap_81");
        at_time(34.0);
        stim_done = 1'b1;
    end

    initial begin
        chk_t e;
        while (!(stim_done && exp_q.size() == 0)) begin
            if (exp_q.size() != 0 && $realtime >= exp_q[0].t - 0.05) begin
                e = exp_q.pop_front();
                checks++;
                if (nstate !== e.v) begin
                    failures++;
                    $display("FAIL %s: nstate=%h expected=%h at t=%0t", e.name, nstate, e.v, $realtime);
                end
            end else begin
                #0.1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500;
        failures++;
        $display("FAIL watchdog: pending=%0d expected=0", exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
